// File: rtl/dct_pkg.sv
// dct_pkg: shared sizes, read FSM states and zigzag tables for the 8x8 zigzag reader
package dct_pkg;
    localparam int DATA_W = 12;
    localparam int BLK_N = 8;
    localparam int BLK_SZ = 64;
    localparam logic [5:0] MAX_IDX = 6'd63;

    typedef enum logic {IDLE, DRAIN} rd_state_t;

    localparam int ZZ_TABLE [BLK_SZ] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam int ZZ_INV [BLK_SZ] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };
endpackage

// File: rtl/dct_pingpong_bank.sv
// dct_pingpong_bank: two 64-entry coefficient banks with row writes, element reads and full flags (EOB tracking under DCT_ZIGZAG_EOB_EN)
module dct_pingpong_bank
    import dct_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_en,
    input  logic [8*DATA_W-1:0]     coef_in,
    input  logic [1:0]              clr,
    input  logic                    rd_sel,
    input  logic [5:0]              rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic [1:0]              full,
    output logic                    in_ready,
    output logic                    overflow,
    output logic [1:0][5:0]         last_idx
);
    logic [DATA_W-1:0] mem [2][BLK_SZ];
    logic wr_bank, wr;
    logic [2:0] row;
    logic [1:0] set;

    // a row lands only when the write bank has room; the 8th row marks the bank full
    always_comb begin
        wr = in_en && !full[wr_bank];
        set = (wr && row == 3'd7) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    end

    // row storage: eight elements written side by side at raster row*8+col
    always_ff @(posedge clk) begin
        if (wr)
            for (int j = 0; j < BLK_N; j++)
                mem[wr_bank][{row, 3'(j)}] <= coef_in[j*DATA_W +: DATA_W];
    end

    // fill bookkeeping: full flags, write bank, row counter and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
            wr_bank <= 1'b0;
            row <= 3'd0;
            overflow <= 1'b0;
        end else begin
            full <= (full & ~clr) | set;
            if (in_en && full[wr_bank])
                overflow <= 1'b1;
            if (wr) begin
                row <= row + 3'd1;
                if (row == 3'd7)
                    wr_bank <= ~wr_bank;
            end
        end
    end

    assign rd_data = mem[rd_sel][rd_addr];
    assign in_ready = !full[wr_bank];

`ifdef DCT_ZIGZAG_EOB_EN
    logic [1:0][5:0] eob_q;
    logic [5:0] row_max;

    // running highest nonzero zigzag index; restarting at row 0 keeps DC counted
    always_comb begin
        row_max = (row == 3'd0) ? 6'd0 : eob_q[wr_bank];
        for (int j = 0; j < BLK_N; j++)
            if (coef_in[j*DATA_W +: DATA_W] != '0 && ZZ_INV[{row, 3'(j)}] > int'(row_max))
                row_max = 6'(ZZ_INV[{row, 3'(j)}]);
    end

    // per-bank end-of-block index captured alongside each row write
    always_ff @(posedge clk) begin
        if (rst)
            eob_q <= '0;
        else if (wr)
            eob_q[wr_bank] <= row_max;
    end

    assign last_idx = eob_q;
`else
    assign last_idx = {MAX_IDX, MAX_IDX};
`endif
endmodule

// File: rtl/dct_zigzag_reader.sv
// dct_zigzag_reader: buffers 8x8 DCT row blocks in ping-pong banks and replays them in zigzag order; DCT_ZIGZAG_EOB_EN enables end-of-block truncation
module dct_zigzag_reader
    import dct_pkg::*;
(
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [8*DATA_W-1:0]      coef_in,
    input  logic                     in_en,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] coef_out,
    output logic [5:0]               out_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     out_eob,
    output logic                     overflow
);
    rd_state_t state;
    logic rd_bank, nxt_bank, fire, done, load, nxt_last, nxt_eob;
    logic [1:0] full, clr;
    logic [1:0][5:0] last_idx;
    logic [5:0] nxt_zz, rd_addr;
    logic [DATA_W-1:0] rd_data;

    dct_pingpong_bank u_bank (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .in_en    (in_en),
        .coef_in  (coef_in),
        .clr      (clr),
        .rd_sel   (nxt_bank),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .full     (full),
        .in_ready (in_ready),
        .overflow (overflow),
        .last_idx (last_idx)
    );

    // pick the next beat: step within the block, hop to the other full bank, or start from idle
    always_comb begin
        fire = (state == DRAIN) && out_ready;
        done = fire && out_last;
        nxt_bank = done ? ~rd_bank : rd_bank;
        nxt_zz = (fire && !out_last) ? out_idx + 6'd1 : 6'd0;
        load = (state == IDLE) ? full[rd_bank] : fire && (!out_last || full[~rd_bank]);
        clr = done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
        rd_addr = 6'(ZZ_TABLE[nxt_zz]);
        nxt_last = nxt_zz == last_idx[nxt_bank];
`ifdef DCT_ZIGZAG_EOB_EN
        nxt_eob = nxt_last && last_idx[nxt_bank] != MAX_IDX;
`else
        nxt_eob = 1'b0;
`endif
    end

    // read FSM with registered output beat; holds everything while the consumer stalls
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            rd_bank <= 1'b0;
            out_valid <= 1'b0;
            coef_out <= '0;
            out_idx <= 6'd0;
            out_last <= 1'b0;
            out_eob <= 1'b0;
        end else begin
            if (done)
                rd_bank <= ~rd_bank;
            if (load) begin
                state <= DRAIN;
                out_valid <= 1'b1;
                coef_out <= rd_data;
                out_idx <= nxt_zz;
                out_last <= nxt_last;
                out_eob <= nxt_eob;
            end else if (done) begin
                state <= IDLE;
                out_valid <= 1'b0;
                out_last <= 1'b0;
                out_eob <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dct_zigzag_reader.sv
// tb_dct_zigzag_reader: directed checks of zigzag replay, stalls, ping-pong overflow, signed extremes and reset
module tb_dct_zigzag_reader;
    logic clk = 1'b0;
    logic sys_rst, in_en, out_ready;
    logic [95:0] coef_in;
    logic in_ready, out_valid, out_last, out_eob, overflow;
    logic [11:0] coef_out;
    logic [5:0] out_idx;
    int n_cmp = 0;
    int n_err = 0;
    int zz [64];

    dct_zigzag_reader dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .coef_in   (coef_in),
        .in_en     (in_en),
        .in_ready  (in_ready),
        .coef_out  (coef_out),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_eob   (out_eob),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    function automatic logic [11:0] elem(input int kind, input int r);
        case (kind)
            0: return 12'(r);
            1: return 12'(r + 200);
            2: return 12'd1000;
            3: return (r < 8) ? 12'h800 : ((r >= 56) ? 12'h7FF : 12'h000);
            4: return 12'(r + 300);
            5: return (r == 0) ? 12'd5 : ((r == 9) ? 12'hFFD : 12'h000);
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [95:0] row_of(input int kind, input int k);
        logic [95:0] v;
        v = '0;
        for (int j = 0; j < 8; j++)
            v[j*12 +: 12] = elem(kind, k*8 + j);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_coef"}, 32'(coef_out), 0);
        chk({tag, "_idx"}, 32'(out_idx), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_eob"}, 32'(out_eob), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_ready"}, 32'(in_ready), 1);
    endtask

    task automatic beat_check(input int kind, input int k, input int n, input bit eob);
        chk($sformatf("b%0d_valid_%0d", kind, k), 32'(out_valid), 1);
        chk($sformatf("b%0d_coef_%0d", kind, k), 32'(coef_out), 32'(elem(kind, zz[k])));
        chk($sformatf("b%0d_idx_%0d", kind, k), 32'(out_idx), k);
        chk($sformatf("b%0d_last_%0d", kind, k), 32'(out_last), 32'(k == n - 1));
        chk($sformatf("b%0d_eob_%0d", kind, k), 32'(out_eob), 32'(eob && k == n - 1));
    endtask

    task automatic send_block(input int kind);
        for (int k = 0; k < 8; k++) begin
            in_en = 1'b1;
            coef_in = row_of(kind, k);
            @(negedge clk);
        end
        in_en = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid; i++)
            @(negedge clk);
        chk("wait_valid", 32'(out_valid), 1);
    endtask

    task automatic drain(input int kind, input int n, input bit eob, input bit stall);
        for (int k = 0; k < n; k++) begin
            beat_check(kind, k, n, eob);
            if (stall) begin
                out_ready = 1'b0;
                @(negedge clk);
                chk($sformatf("b%0d_stall_coef_%0d", kind, k), 32'(coef_out), 32'(elem(kind, zz[k])));
                chk($sformatf("b%0d_stall_idx_%0d", kind, k), 32'(out_idx), k);
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk($sformatf("b%0d_drained_valid", kind), 32'(out_valid), 0);
    endtask

    initial begin
        int p;
        p = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[p] = r*8 + (s - r);
                    p++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    zz[p] = r*8 + (s - r);
                    p++;
                end
            end
        end

        sys_rst = 1'b1;
        in_en = 1'b0;
        out_ready = 1'b1;
        coef_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset("por");
        sys_rst = 1'b0;

        send_block(0);
        chk("lat_t1_valid", 32'(out_valid), 0);
        @(negedge clk);
        drain(0, 64, 1'b0, 1'b0);

        send_block(1);
        wait_valid();
        drain(1, 64, 1'b0, 1'b1);

        send_block(3);
        wait_valid();
        drain(3, 64, 1'b0, 1'b0);
        chk("ovf_before_burst", 32'(overflow), 0);

        for (int c = 1; c <= 137; c++) begin
            in_en = (c <= 24);
            coef_in = (c <= 24) ? row_of((c <= 8) ? 4 : ((c <= 16) ? 1 : 2), (c - 1) % 8) : '0;
            @(negedge clk);
            if (c == 16) begin
                chk("burst_ready_c16", 32'(in_ready), 0);
                chk("burst_ovf_c16", 32'(overflow), 0);
            end
            if (c == 17) chk("burst_ovf_c17", 32'(overflow), 1);
            if (c == 24) chk("burst_ready_c24", 32'(in_ready), 0);
            if (c == 72) chk("burst_ready_c72", 32'(in_ready), 0);
            if (c == 73) chk("burst_ready_c73", 32'(in_ready), 1);
            if (c >= 9 && c <= 72) beat_check(4, c - 9, 64, 1'b0);
            if (c >= 73 && c <= 136) beat_check(1, c - 73, 64, 1'b0);
            if (c == 137) chk("burst_end_valid", 32'(out_valid), 0);
        end
        in_en = 1'b0;

        for (int k = 0; k < 4; k++) begin
            in_en = 1'b1;
            coef_in = row_of(2, k);
            @(negedge clk);
        end
        in_en = 1'b0;
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        chk_reset("rst_partial");

        send_block(1);
        wait_valid();
        for (int k = 0; k < 20; k++) begin
            beat_check(1, k, 64, 1'b0);
            @(negedge clk);
        end
        beat_check(1, 20, 64, 1'b0);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        chk_reset("rst_drain");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet_%0d", i), 32'(out_valid), 0);
        end

        send_block(0);
        chk("lat2_t1_valid", 32'(out_valid), 0);
        @(negedge clk);
        drain(0, 64, 1'b0, 1'b0);

`ifdef DCT_ZIGZAG_EOB_EN
        send_block(5);
        wait_valid();
        drain(5, 5, 1'b1, 1'b0);
        send_block(6);
        wait_valid();
        drain(6, 1, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
